data_path: RTL and testbench
============================

DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 SHALL provide ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL provide: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: instr  in  32  current instruction word.
REQ-004 SHALL provide: readData  in  32  data-memory load value.
REQ-005 SHALL provide: branch  in  1  conditional-branch control.
REQ-006 SHALL provide: jump  in  1  unconditional-jump control.
REQ-007 SHALL provide: resultSrc  in  2  register write-back select.
REQ-008 SHALL provide: ALUControl  in  3  ALU operation select.
REQ-009 SHALL provide: ALUSrc  in  1  ALU operand B select (0 = rs2 data, 1 = immediate).
REQ-010 SHALL provide: inmSrc  in  2  immediate format select.
REQ-011 SHALL provide: regWrite  in  1  register-file write enable.
REQ-012 SHALL provide: pc  out  16  program counter.
REQ-013 SHALL provide: ALUResult  out  32  ALU output, also the data-memory address.
REQ-014 SHALL provide: writeData  out  32  rs2 read data, used as store data.
REQ-015 SHALL provide: zero  out  1  high when ALUResult == 0.
REQ-016 SHALL provide decode outputs: opecode (out, 7, instr[6:0]); f3 (out, 3, instr[14:12]); f7 (out, 1, instr[30]).

Function
REQ-017 Register file SHALL be 32 x 32 bits. Reads are combinational: rs1 = instr[19:15], rs2 = instr[24:20].
REQ-018 Writes SHALL occur at the rising clk edge when regWrite=1, to rd = instr[11:7]. Writes to x0 are ignored; x0 always reads 0.
REQ-019 Immediate SHALL be sign-extended to 32 bits, selected by inmSrc:
- 00 I-type: instr[31:20]
- 01 S-type: {instr[31:25], instr[11:7]}
- 10 B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- 11 J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
REQ-020 ALU SHALL compute on operand A = rs1 data and B = ALUSrc mux. Operations by ALUControl:
- 000 add; 001 sub; 010 and; 011 or; 100 xor
- 101 signed slt (result 1/0); 110 sll by B[4:0]; 111 srl by B[4:0]
- Add and sub wrap modulo 2^32.
REQ-021 pcPlus4 = pc + 4 and pcTarget = pc + imm[15:0]. Both SHALL be 16-bit and wrap modulo 2^16.
REQ-022 pcSrc = (branch AND zero) OR jump. Next pc SHALL be pcTarget when pcSrc=1, otherwise pcPlus4. pc loads at every rising clk edge.
REQ-023 Write-back result SHALL be selected by resultSrc:
- 00 ALUResult
- 01 readData
- 10 pcPlus4, zero-extended to 32 bits
- 11 immediate
REQ-024 All outputs except pc SHALL be combinational from instr, the register contents, readData and the control inputs, with no added latency. A single instruction completes in one cycle.
REQ-025 A register write and a read of the same register in the same cycle SHALL return the old value until the clock edge.

Reset
REQ-026 rst_n=0 SHALL asynchronously set pc=0 and all 32 registers to 0, independent of clk.
REQ-027 While rst_n=0, pc and registers SHALL hold 0 and writes are blocked. The first update occurs on the first rising clk edge after rst_n goes high.
REQ-028 Reset asserted mid-operation SHALL discard the pending write and the pending pc update.

Verification
REQ-029 Reset, then release; instr=0x00108100 (addi x2,x1,1), ALUSrc=1, inmSrc=00, ALUControl=000, resultSrc=00, regWrite=1 -> required response:
- pc=0 and ALUResult=1 before the first edge
- after the edge: pc=4, x2=1
- opecode=0000000, f3=000, f7=0
REQ-030 Same instr held for several cycles -> pc SHALL step 0, 4, 8, 12; x2 remains 1 (x1 stays 0).
REQ-031 rd=x0 with regWrite=1 and a nonzero result -> a subsequent read of x0 SHALL return 0.
REQ-032 beq x0,x0,+8: branch=1, ALUControl=001, ALUSrc=0, inmSrc=10, pc=4 -> required response:
- zero=1
- next pc=12
- same instr with branch=0 -> next pc=8
REQ-033 jal x1,+16 at pc=8: jump=1, inmSrc=11, resultSrc=10 -> next pc=24 and x1=12.
REQ-034 lw path: resultSrc=01, readData=0xDEADBEEF, regWrite=1 -> rd=0xDEADBEEF. Separately, assert rst_n low mid-cycle -> pc=0 immediately, before any clock edge.

Source files
------------

// File: rtl/data_path.sv
// Single-cycle RISC-V style datapath: register file, immediate generator, ALU,
// PC sequencing and write-back select. Only the PC and registers are stateful.
module data_path (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] readData,
  input  logic        branch,
  input  logic        jump,
  input  logic [1:0]  resultSrc,
  input  logic [2:0]  ALUControl,
  input  logic        ALUSrc,
  input  logic [1:0]  inmSrc,
  input  logic        regWrite,
  output logic [15:0] pc,
  output logic [31:0] ALUResult,
  output logic [31:0] writeData,
  output logic        zero,
  output logic [6:0]  opecode,
  output logic [2:0]  f3,
  output logic        f7
);

  logic [31:0] rf_reg [32];
  logic [15:0] pc_reg;
  logic [15:0] pc_next;
  logic [15:0] pc_plus4;
  logic [15:0] pc_target;
  logic        pc_src;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [31:0] src_b;
  logic [31:0] alu_out;
  logic [31:0] result;

  assign opecode = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[30];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign rd      = instr[11:7];

  // x0 is never written, but force the zero read so it holds regardless
  assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf_reg[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf_reg[rs2];

  always_comb begin
    imm = 32'd0;
    case (inmSrc)
      2'b00: imm = {{20{instr[31]}}, instr[31:20]};
      2'b01: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      2'b11: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  assign src_b = ALUSrc ? imm : rd2;

  always_comb begin
    alu_out = 32'd0;
    case (ALUControl)
      3'b000: alu_out = rd1 + src_b;
      3'b001: alu_out = rd1 - src_b;
      3'b010: alu_out = rd1 & src_b;
      3'b011: alu_out = rd1 | src_b;
      3'b100: alu_out = rd1 ^ src_b;
      3'b101: alu_out = {31'd0, $signed(rd1) < $signed(src_b)};
      3'b110: alu_out = rd1 << src_b[4:0];
      3'b111: alu_out = rd1 >> src_b[4:0];
      default: alu_out = 32'd0;
    endcase
  end

  assign ALUResult = alu_out;
  assign zero      = (alu_out == 32'd0);
  assign writeData = rd2;

  assign pc_plus4  = pc_reg + 16'd4;
  assign pc_target = pc_reg + imm[15:0];
  assign pc_src    = (branch & zero) | jump;
  assign pc_next   = pc_src ? pc_target : pc_plus4;
  assign pc        = pc_reg;

  always_comb begin
    result = alu_out;
    case (resultSrc)
      2'b00: result = alu_out;
      2'b01: result = readData;
      2'b10: result = {16'd0, pc_plus4};
      2'b11: result = imm;
      default: result = alu_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= 16'd0;
      for (int i = 0; i < 32; i++) begin
        rf_reg[i] <= 32'd0;
      end
    end else begin
      pc_reg <= pc_next;
      if (regWrite && (rd != 5'd0)) begin
        rf_reg[rd] <= result;
      end
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed instruction scenarios plus random
// instructions compared against an arithmetic model of the architectural state.
module tb_data_path;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] readData;
  logic        branch;
  logic        jump;
  logic [1:0]  resultSrc;
  logic [2:0]  ALUControl;
  logic        ALUSrc;
  logic [1:0]  inmSrc;
  logic        regWrite;
  logic [15:0] pc;
  logic [31:0] ALUResult;
  logic [31:0] writeData;
  logic        zero;
  logic [6:0]  opecode;
  logic [2:0]  f3;
  logic        f7;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic [15:0] mpc;
  logic [31:0] m_result;
  logic [15:0] m_npc;

  data_path dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .readData(readData),
    .branch(branch), .jump(jump), .resultSrc(resultSrc), .ALUControl(ALUControl),
    .ALUSrc(ALUSrc), .inmSrc(inmSrc), .regWrite(regWrite), .pc(pc),
    .ALUResult(ALUResult), .writeData(writeData), .zero(zero),
    .opecode(opecode), .f3(f3), .f7(f7)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic int bits(input logic [31:0] w, input int lo, input int n);
    return int'((w >> lo) % (32'd1 << n));
  endfunction

  // Immediate rebuilt from field values with plain arithmetic
  function automatic logic [31:0] m_imm(input logic [31:0] i, input logic [1:0] s);
    int neg;
    int v;
    neg = (i >> 31) != 0 ? 1 : 0;
    case (s)
      2'd0: v = -neg * 2048 + bits(i, 20, 11);
      2'd1: v = -neg * 2048 + bits(i, 25, 6) * 32 + bits(i, 7, 5);
      2'd2: v = -neg * 4096 + bits(i, 7, 1) * 2048 + bits(i, 25, 6) * 32 + bits(i, 8, 4) * 2;
      default: v = -neg * 1048576 + bits(i, 12, 8) * 4096 + bits(i, 20, 1) * 2048
                   + bits(i, 21, 10) * 2;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
    mpc = 16'd0;
  endtask

  // Drive one instruction, settle, and compare the combinational outputs.
  task automatic apply(input logic [31:0] i, input logic [31:0] rdata, input logic br,
                       input logic jp, input logic [1:0] rs, input logic [2:0] ac,
                       input logic as, input logic [1:0] is, input logic rw);
    logic [31:0] a, b, im, alu;
    logic [15:0] p4;
    instr = i; readData = rdata; branch = br; jump = jp; resultSrc = rs;
    ALUControl = ac; ALUSrc = as; inmSrc = is; regWrite = rw;
    #2;
    im  = m_imm(i, is);
    a   = mregs[bits(i, 15, 5)];
    b   = as ? im : mregs[bits(i, 20, 5)];
    alu = m_alu(ac, a, b);
    p4  = mpc + 16'd4;
    m_npc = ((br && alu == 32'd0) || jp) ? mpc + im[15:0] : p4;
    case (rs)
      2'd0: m_result = alu;
      2'd1: m_result = rdata;
      2'd2: m_result = 32'(p4);
      default: m_result = im;
    endcase
    check("pc", 32'(pc), 32'(mpc));
    check("alu", ALUResult, alu);
    check("zero", 32'(zero), 32'(alu == 32'd0));
    check("wdata", writeData, mregs[bits(i, 20, 5)]);
    check("decode", {22'd0, f7, f3, opecode},
          {22'd0, 1'(bits(i, 30, 1)), 3'(bits(i, 12, 3)), 7'(bits(i, 0, 7))});
  endtask

  task automatic tick();
    @(posedge clk);
    if (regWrite && bits(instr, 7, 5) != 0) mregs[bits(instr, 7, 5)] = m_result;
    mpc = m_npc;
    #1;
    check("pc_next", 32'(pc), 32'(mpc));
    $display("cycle instr=%08h pc=%04h alu=%08h", instr, pc, ALUResult);
  endtask

  task automatic read_reg(input int r, input logic [31:0] exp, input string tag);
    apply((32'(r) << 15) | 32'h13, 32'd0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 0);
    check(tag, ALUResult, exp);
    tick();
  endtask

  // Assert reset away from the clock edge, hold it across an edge, release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pc_async", 32'(pc), 32'd0);
    @(posedge clk);
    #1;
    check("rst_pc_hold", 32'(pc), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    instr = 32'd0; readData = 32'd0; branch = 0; jump = 0; resultSrc = 2'd0;
    ALUControl = 3'd0; ALUSrc = 0; inmSrc = 2'd0; regWrite = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // addi x2,x1,1 repeated
    apply(32'h00108100, 32'd0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 1);
    check("addi_pc0", 32'(pc), 32'd0);
    check("addi_alu", ALUResult, 32'd1);
    check("addi_dec", {22'd0, f7, f3, opecode}, 32'd0);
    tick();
    check("addi_pc4", 32'(pc), 32'd4);
    for (int k = 1; k < 4; k++) begin
      apply(32'h00108100, 32'd0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 1);
      check("addi_step", 32'(pc), 32'(4 * k));
      tick();
    end
    read_reg(2, 32'd1, "x2_val");

    // addi x0,x2,5 must not change x0
    apply(32'h00510013, 32'd0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 1);
    tick();
    read_reg(0, 32'd0, "x0_zero");

    // beq x0,x0,+8 from pc=4, taken then not taken
    do_reset();
    apply(32'h00000013, 32'd0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 0);
    tick();
    apply(32'h00000463, 32'd0, 1, 0, 2'd0, 3'd1, 0, 2'd2, 0);
    check("beq_zero", 32'(zero), 32'd1);
    tick();
    check("beq_taken", 32'(pc), 32'd12);
    do_reset();
    apply(32'h00000013, 32'd0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 0);
    tick();
    apply(32'h00000463, 32'd0, 0, 0, 2'd0, 3'd1, 0, 2'd2, 0);
    tick();
    check("beq_not", 32'(pc), 32'd8);

    // jal x1,+16 at pc=8
    apply(32'h010000EF, 32'd0, 0, 1, 2'd2, 3'd0, 0, 2'd3, 1);
    tick();
    check("jal_pc", 32'(pc), 32'd24);
    read_reg(1, 32'd12, "jal_link");

    // lw x5,0(x0)
    apply(32'h00002283, 32'hDEADBEEF, 0, 0, 2'd1, 3'd0, 1, 2'd0, 1);
    tick();
    read_reg(5, 32'hDEADBEEF, "lw_val");

    // random instructions
    for (int n = 0; n < 300; n++) begin
      apply($urandom, $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0),
            2'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      tick();
    end

    // mid-cycle reset discards a pending write to x7
    read_reg(0, 32'd0, "pre_rst");
    apply(32'h7FF00393, 32'd0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 1);
    do_reset();
    read_reg(7, 32'd0, "rst_discard");
    check("rst_restart", 32'(pc), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
